// File: rtl/wbck_arb_scoreboard_pkg.sv
// rtl/wbck_arb_scoreboard_pkg.sv - shared widths, source encodings and helpers for write-back
package wbck_arb_scoreboard_pkg;

   localparam int XLEN        = 32;
   localparam int RFIDX_WIDTH = 5;
   localparam int RFREG_NUM   = 32;

   localparam logic WB_SRC_ALU = 1'b0;
   localparam logic WB_SRC_LSU = 1'b1;

   // One-hot register mask; x0 is never tracked so it always yields zero.
   function automatic logic [RFREG_NUM-1:0] rf_onehot(input logic [RFIDX_WIDTH-1:0] idx);
      logic [RFREG_NUM-1:0] m;
      m = '0;
      if (idx != '0) m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/wbck_rr_arb.sv
// rtl/wbck_rr_arb.sv - 2-way round-robin arbiter between ALU and long-latency write-back
module wbck_rr_arb
   import wbck_arb_scoreboard_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic rr_last_q;
   logic rr_last_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_last_q <= WB_SRC_LSU;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end

   // On a tie the source that did not win last time is granted.
   always_comb begin
      gnt_o = 2'b00;
      if (rst) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (rr_last_q == WB_SRC_LSU) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   always_comb begin
      rr_last_d = rr_last_q;
      if (gnt_o[WB_SRC_LSU]) begin
         rr_last_d = WB_SRC_LSU;
      end else if (gnt_o[WB_SRC_ALU]) begin
         rr_last_d = WB_SRC_ALU;
      end
   end

endmodule

// File: rtl/wbck_arb_scoreboard.sv
// rtl/wbck_arb_scoreboard.sv - RF write-back arbiter with long-latency pending scoreboard
module wbck_arb_scoreboard
   import wbck_arb_scoreboard_pkg::*;
#(
   parameter int MAX_OUT = 4,
   parameter int CNT_W   = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alu_wbck_valid,
   output logic                   alu_wbck_ready,
   input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
   input  logic [XLEN-1:0]        alu_wbck_dat,
   input  logic                   lsu_wbck_valid,
   output logic                   lsu_wbck_ready,
   input  logic [RFIDX_WIDTH-1:0] lsu_wbck_idx,
   input  logic [XLEN-1:0]        lsu_wbck_dat,
   input  logic                   iss_valid,
   input  logic                   iss_long,
   input  logic                   iss_rd_wen,
   input  logic [RFIDX_WIDTH-1:0] iss_rd_idx,
   input  logic                   iss_rs1_ren,
   input  logic [RFIDX_WIDTH-1:0] iss_rs1_idx,
   input  logic                   iss_rs2_ren,
   input  logic [RFIDX_WIDTH-1:0] iss_rs2_idx,
   output logic                   iss_stall,
   output logic                   wbck_dest_wen,
   output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
   output logic [XLEN-1:0]        wbck_dest_dat,
   output logic                   sb_busy
);

   logic [1:0]           req;
   logic [1:0]           gnt;
   logic                 alu_gnt;
   logic                 lsu_gnt;

   logic [RFREG_NUM-1:0] pending_q;
   logic [RFREG_NUM-1:0] pending_d;
   logic [RFREG_NUM-1:0] set_mask;
   logic [RFREG_NUM-1:0] clr_mask;
   logic [CNT_W-1:0]     out_cnt_q;
   logic [CNT_W-1:0]     out_cnt_d;

   logic                 hazard;
   logic                 cnt_full;
   logic                 iss_accept;
   logic                 cnt_inc;
   logic                 cnt_dec;

   assign req = {lsu_wbck_valid, alu_wbck_valid};

   wbck_rr_arb u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (req),
      .gnt_o (gnt)
   );

   assign alu_gnt        = gnt[WB_SRC_ALU];
   assign lsu_gnt        = gnt[WB_SRC_LSU];
   assign alu_wbck_ready = alu_gnt;
   assign lsu_wbck_ready = lsu_gnt;

   always_comb begin
      wbck_dest_idx = '0;
      wbck_dest_dat = '0;
      if (alu_gnt) begin
         wbck_dest_idx = alu_wbck_idx;
         wbck_dest_dat = alu_wbck_dat;
      end else if (lsu_gnt) begin
         wbck_dest_idx = lsu_wbck_idx;
         wbck_dest_dat = lsu_wbck_dat;
      end
   end

   // x0 writes still complete the handshake but never reach the register file.
   assign wbck_dest_wen = (alu_gnt || lsu_gnt) && (wbck_dest_idx != '0);

   assign cnt_full = (out_cnt_q == CNT_W'(MAX_OUT));
   assign hazard   = (iss_rs1_ren && pending_q[iss_rs1_idx])
                  || (iss_rs2_ren && pending_q[iss_rs2_idx])
                  || (iss_rd_wen  && pending_q[iss_rd_idx])
                  || (iss_long    && cnt_full);

   assign iss_stall  = !rst || hazard;
   assign iss_accept = iss_valid && !iss_stall;
   assign cnt_inc    = iss_accept && iss_long;
   assign cnt_dec    = lsu_gnt;

   assign set_mask = (cnt_inc && iss_rd_wen) ? rf_onehot(iss_rd_idx) : '0;
   assign clr_mask = lsu_gnt ? rf_onehot(lsu_wbck_idx) : '0;

   // Set is applied after clear so a same-cycle re-issue of a retiring register stays pending.
   always_comb begin
      pending_d    = (pending_q & ~clr_mask) | set_mask;
      pending_d[0] = 1'b0;
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (cnt_inc && !cnt_dec) begin
         out_cnt_d = out_cnt_q + CNT_W'(1);
      end else if (cnt_dec && !cnt_inc && (out_cnt_q != '0)) begin
         out_cnt_d = out_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending_q <= '0;
         out_cnt_q <= '0;
      end else begin
         pending_q <= pending_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   assign sb_busy = rst && (out_cnt_q != '0);

`ifndef SYNTHESIS
   lsu_underflow_a: assert property (@(posedge clk) disable iff (!rst)
      !(cnt_dec && (out_cnt_q == '0)));
`endif

endmodule
